// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: in-place radix-2 DIT FFT sequencer (start/busy/done, RAM read/write ports, twiddle index, butterfly result capture)
module fft_stage_ctrl #(
  parameter int LOG2_N  = 3,
  parameter int WORD_SZ = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_rd_en,
  output logic [LOG2_N-1:0]   o_rd_addr_a,
  output logic [LOG2_N-1:0]   o_rd_addr_b,
  output logic [LOG2_N-2:0]   o_tw_addr,
  input  logic [WORD_SZ-1:0]  i_bf_A,
  input  logic [WORD_SZ-1:0]  i_bf_B,
  output logic                o_wr_en,
  output logic [LOG2_N-1:0]   o_wr_addr_a,
  output logic [LOG2_N-1:0]   o_wr_addr_b,
  output logic [WORD_SZ-1:0]  o_wr_data_a,
  output logic [WORD_SZ-1:0]  o_wr_data_b
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = $clog2(LOG2_N) + 1;
  typedef enum logic [2:0] {IDLE, RD, EX, WR, DONE} state_t;
  state_t state, state_nx;
  logic [SW-1:0] s;
  logic [LOG2_N-1:0] k, half, j, g, addr_a, addr_b;
  logic [LOG2_N-2:0] tw;
  logic last_k, last;
  always_comb begin
    half   = LOG2_N'(1) << s;
    j      = k & (half - LOG2_N'(1));
    g      = k >> s;
    addr_a = ((g << s) << 1) | j;
    addr_b = addr_a + half;
    tw     = (LOG2_N-1)'(j << (LOG2_N - 1 - s));
    last_k = k == LOG2_N'(N/2 - 1);
    last   = last_k && s == SW'(LOG2_N - 1);
  end
  always_comb begin
    state_nx = state == IDLE ? (i_start ? RD : IDLE) :
               state == RD   ? EX :
               state == EX   ? WR :
               state == WR   ? (last ? DONE : RD) : IDLE;
  end
  assign o_busy      = state == RD || state == EX || state == WR;
  assign o_done      = state == DONE;
  assign o_rd_en     = state == RD;
  assign o_wr_en     = state == WR;
  assign o_rd_addr_a = o_rd_en ? addr_a : '0;
  assign o_rd_addr_b = o_rd_en ? addr_b : '0;
  assign o_tw_addr   = o_rd_en ? tw : '0;
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s           <= '0;
      k           <= '0;
      o_wr_addr_a <= '0;
      o_wr_addr_b <= '0;
      o_wr_data_a <= '0;
      o_wr_data_b <= '0;
    end else begin
      if (state == EX) begin
        o_wr_addr_a <= addr_a;
        o_wr_addr_b <= addr_b;
        o_wr_data_a <= i_bf_A;
        o_wr_data_b <= i_bf_B;
      end
      if (state == WR) begin
        k <= last_k ? '0 : k + LOG2_N'(1);
        s <= last ? '0 : last_k ? s + SW'(1) : s;
      end
    end
  end
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: directed bench with sample RAM, twiddle ROM and butterfly model around fft_stage_ctrl
module tb_fft_stage_ctrl;
  logic clk = 1'b0, rst, start;
  logic busy, done, rd_en, wr_en;
  logic [2:0] rd_a, rd_b, wr_a, wr_b;
  logic [1:0] tw_addr;
  logic [31:0] bf_a, bf_b, wd_a, wd_b;
  logic [31:0] mem [8];
  logic [31:0] rom [4] = '{32'h0040_0000, 32'h002d_ffd3, 32'h0000_ffc0, 32'hffd3_ffd3};
  logic [31:0] ra, rb, tq;
  logic ld_en;
  logic [2:0] ld_addr;
  logic [31:0] ld_data;
  logic [81:0] all_out;
  int n_cmp = 0, n_err = 0;
  int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  always #5 clk = ~clk;

  fft_stage_ctrl #(.LOG2_N(3), .WORD_SZ(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_rd_en(rd_en), .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_tw_addr(tw_addr),
    .i_bf_A(bf_a), .i_bf_B(bf_b),
    .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b),
    .o_wr_data_a(wd_a), .o_wr_data_b(wd_b)
  );

  assign all_out = {busy, done, rd_en, wr_en, rd_a, rd_b, tw_addr, wr_a, wr_b, wd_a, wd_b};

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    if (wr_en) begin
      mem[wr_a] <= wd_a;
      mem[wr_b] <= wd_b;
    end
    if (rd_en) begin
      ra <= mem[rd_a];
      rb <= mem[rd_b];
      tq <= rom[tw_addr];
    end
  end

  // Butterfly: A' = A + W*B, B' = A - W*B, Q6 twiddle product rescaled by >>> 6.
  logic signed [15:0] br, bi, wr_, wi;
  logic signed [31:0] pr, pi;
  logic [15:0] ar, ai;
  always_comb begin
    ar  = ra[31:16];
    ai  = ra[15:0];
    br  = rb[31:16];
    bi  = rb[15:0];
    wr_ = tq[31:16];
    wi  = tq[15:0];
    pr  = (br * wr_ - bi * wi) >>> 6;
    pi  = (br * wi + bi * wr_) >>> 6;
    bf_a = {ar + pr[15:0], ai + pi[15:0]};
    bf_b = {ar - pr[15:0], ai - pi[15:0]};
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] w0, input logic [31:0] rest);
    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_addr = 3'(i);
      ld_data = i == 0 ? w0 : rest;
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  task automatic check_mem(input string tag, input logic [31:0] w0, input logic [31:0] rest);
    for (int i = 0; i < 8; i++) chk(tag, 128'(mem[i]), 128'(i == 0 ? w0 : rest));
  endtask

  task automatic run(input int p1, input int p2);
    int ri = 0, wi = 0, done_at = 0, n_done = 0, n_busy = 0, both = 0;
    start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = c == p1 || c == p2;
      if (rd_en) begin
        if (ri < 12) begin
          chk("rd_addr_a", 128'(rd_a), 128'(exp_a[ri]));
          chk("rd_addr_b", 128'(rd_b), 128'(exp_b[ri]));
          chk("tw_addr", 128'(tw_addr), 128'(exp_t[ri]));
        end
        ri++;
      end
      if (wr_en) begin
        if (wi < 12) begin
          chk("wr_addr_a", 128'(wr_a), 128'(exp_a[wi]));
          chk("wr_addr_b", 128'(wr_b), 128'(exp_b[wi]));
        end
        wi++;
      end
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (busy) n_busy++;
      if (rd_en && wr_en) both++;
    end
    chk("rd_count", 128'(ri), 128'(12));
    chk("wr_count", 128'(wi), 128'(12));
    chk("done_cycle", 128'(done_at), 128'(37));
    chk("done_count", 128'(n_done), 128'(1));
    chk("busy_cycles", 128'(n_busy), 128'(36));
    chk("rd_wr_overlap", 128'(both), 128'(0));
  endtask

  initial begin
    int d1, d2;
    rst = 1'b1;
    start = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'(all_out), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 128'(all_out), 128'(0));
    end

    load(32'h0040_0000, 32'h0);
    run(0, 0);
    check_mem("impulse", 32'h0040_0000, 32'h0040_0000);

    load(32'h0040_0000, 32'h0040_0000);
    run(5, 20);
    check_mem("constant", 32'h0200_0000, 32'h0);

    load(32'h0040_0000, 32'h0);
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("stage1_ex", 128'({busy, rd_en, wr_en}), 128'(3'b100));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", 128'(all_out), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", 128'(all_out), 128'(0));
    load(32'h0040_0000, 32'h0);
    run(0, 0);
    check_mem("impulse_after_reset", 32'h0040_0000, 32'h0040_0000);

    d1 = 0;
    d2 = 0;
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
      if (d2 != 0) start = 1'b0;
    end
    chk("hold_done1", 128'(d1), 128'(37));
    chk("hold_done2", 128'(d2), 128'(75));
    chk("hold_idle", 128'({busy, done}), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
